// File: rtl/cpu_test_sequencer.sv
// cpu_test_sequencer
//    Self-checking harness around the Top CPU core. A small programmable vector
//    table preloads data memory (DM) and the register file (RF) through backdoor
//    write ports while the core is held in reset. The core is then released and
//    the sequencer waits for its done flag, bounded by a timeout. Finally the
//    expected DM words are read back and compared.
//
//    Optional feature: define TSEQ_MISMATCH_CAPTURE_EN to add the fail_exp /
//    fail_act ports, which hold the expected and actual values of the first
//    mismatching check.
//
// Ports
//    clk, rst_n          clock, asynchronous active-low reset
//    cfg_we .. cfg_data  table write port, accepted only while idle
//                        (cfg_chk selects the check table, cfg_idx the entry)
//    start               one-cycle pulse that starts a test from idle
//    dm_we/addr/wdata    DM backdoor; dm_addr is also the check read address
//    dm_rdata            DM read data, valid one cycle after dm_addr
//    rf_we/addr/wdata    RF backdoor write port
//    cpu_reset           active-high reset to the core
//    cpu_done            done flag from the core
//    busy                high in every state except idle
//    pass, fail          sticky result; exactly one is set after a test
//    timed_out           sticky: the failure was caused by the timeout
//    fail_idx            index of the first failing check
//    run_cycles          cycles from core release to done, saturates at TIMEOUT
module cpu_test_sequencer #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 8,
   parameter int RF_AW    = 3,
   parameter int NUM_INIT = 8,
   parameter int NUM_CHK  = 4,
   parameter int TIMEOUT  = 1024,
   localparam int TBL_N   = (NUM_INIT > NUM_CHK) ? NUM_INIT : NUM_CHK,
   localparam int IDX_W   = (TBL_N > 1) ? $clog2(TBL_N) : 1,
   localparam int INIT_W  = (NUM_INIT > 1) ? $clog2(NUM_INIT) : 1,
   localparam int CHK_W   = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1,
   localparam int RC_W    = $clog2(TIMEOUT + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic              cfg_chk,
   input  logic [IDX_W-1:0]  cfg_idx,
   input  logic              cfg_is_rf,
   input  logic              cfg_valid,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [DATA_W-1:0] cfg_data,
   input  logic              start,
   output logic              dm_we,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              rf_we,
   output logic [RF_AW-1:0]  rf_addr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              cpu_reset,
   input  logic              cpu_done,
   output logic              busy,
   output logic              pass,
   output logic              fail,
   output logic              timed_out,
   output logic [CHK_W-1:0]  fail_idx,
   output logic [RC_W-1:0]   run_cycles
`ifdef TSEQ_MISMATCH_CAPTURE_EN
   ,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_act
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_INIT, S_RELEASE, S_RUN, S_CHECK_ADDR, S_CHECK_CMP, S_DONE
   } state_t;

   state_t state;

   logic [INIT_W-1:0] init_idx;
   logic [CHK_W-1:0]  chk_idx;

   // Valid flags are reset so that a reset empties the tables. The payload
   // fields need no reset because they are only read behind a valid flag.
   logic [NUM_INIT-1:0] init_valid;
   logic [NUM_INIT-1:0] init_is_rf;
   logic [ADDR_W-1:0]   init_addr [NUM_INIT];
   logic [DATA_W-1:0]   init_data [NUM_INIT];
   logic [NUM_CHK-1:0]  chk_valid;
   logic [ADDR_W-1:0]   chk_addr  [NUM_CHK];
   logic [DATA_W-1:0]   chk_data  [NUM_CHK];

   logic cfg_wr;
   assign cfg_wr = cfg_we && (state == S_IDLE);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_INIT; gi++) begin : g_init_tbl
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               init_valid[gi] <= 1'b0;
               init_is_rf[gi] <= 1'b0;
            end else if (cfg_wr && !cfg_chk && cfg_idx == IDX_W'(gi)) begin
               init_valid[gi] <= cfg_valid;
               init_is_rf[gi] <= cfg_is_rf;
            end
         end
         always_ff @(posedge clk) begin
            if (cfg_wr && !cfg_chk && cfg_idx == IDX_W'(gi)) begin
               init_addr[gi] <= cfg_addr;
               init_data[gi] <= cfg_data;
            end
         end
      end
      for (gi = 0; gi < NUM_CHK; gi++) begin : g_chk_tbl
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               chk_valid[gi] <= 1'b0;
            end else if (cfg_wr && cfg_chk && cfg_idx == IDX_W'(gi)) begin
               chk_valid[gi] <= cfg_valid;
            end
         end
         always_ff @(posedge clk) begin
            if (cfg_wr && cfg_chk && cfg_idx == IDX_W'(gi)) begin
               chk_addr[gi] <= cfg_addr;
               chk_data[gi] <= cfg_data;
            end
         end
      end
   endgenerate

   // Look ahead to the next valid check entry. dm_addr is registered, so it
   // has to be loaded on the transition into CHECK_ADDR. That way the DM read
   // completes in time for the compare in CHECK_CMP. Invalid entries
   // therefore cost no cycles.
   logic [CHK_W:0]   scan_from;
   logic             nxt_found;
   logic [CHK_W-1:0] nxt_idx;

   always_comb begin
      scan_from = (state == S_CHECK_CMP) ? ({1'b0, chk_idx} + 1'b1) : '0;
      nxt_found = 1'b0;
      nxt_idx   = '0;
      for (int i = NUM_CHK - 1; i >= 0; i--) begin
         if (chk_valid[i] && ((CHK_W + 1)'(i) >= scan_from)) begin
            nxt_found = 1'b1;
            nxt_idx   = CHK_W'(i);
         end
      end
   end

   logic [RC_W-1:0] run_inc;
   assign run_inc = run_cycles + 1'b1;

   logic cmp_bad;
   assign cmp_bad = (dm_rdata != chk_data[chk_idx]);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         init_idx   <= '0;
         chk_idx    <= '0;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_wdata   <= '0;
         rf_we      <= 1'b0;
         rf_addr    <= '0;
         rf_wdata   <= '0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         pass       <= 1'b0;
         fail       <= 1'b0;
         timed_out  <= 1'b0;
         fail_idx   <= '0;
         run_cycles <= '0;
`ifdef TSEQ_MISMATCH_CAPTURE_EN
         fail_exp   <= '0;
         fail_act   <= '0;
`endif
      end else begin
         // Write strobes are single-cycle pulses and only INIT raises them.
         dm_we <= 1'b0;
         rf_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_INIT;
                  init_idx   <= '0;
                  busy       <= 1'b1;
                  pass       <= 1'b0;
                  fail       <= 1'b0;
                  timed_out  <= 1'b0;
                  fail_idx   <= '0;
                  run_cycles <= '0;
`ifdef TSEQ_MISMATCH_CAPTURE_EN
                  fail_exp   <= '0;
                  fail_act   <= '0;
`endif
               end
            end
            S_INIT: begin
               // Entries are issued in index order, so a later duplicate
               // address overwrites an earlier one.
               if (init_valid[init_idx]) begin
                  if (init_is_rf[init_idx]) begin
                     rf_we    <= 1'b1;
                     rf_addr  <= init_addr[init_idx][RF_AW-1:0];
                     rf_wdata <= init_data[init_idx];
                  end else begin
                     dm_we    <= 1'b1;
                     dm_addr  <= init_addr[init_idx];
                     dm_wdata <= init_data[init_idx];
                  end
               end
               if (init_idx == INIT_W'(NUM_INIT - 1)) begin
                  state <= S_RELEASE;
               end else begin
                  init_idx <= init_idx + 1'b1;
               end
            end
            S_RELEASE: begin
               // The last init write is still visible this cycle, while the
               // core is still held in reset.
               cpu_reset <= 1'b0;
               state     <= S_RUN;
            end
            S_RUN: begin
               run_cycles <= run_inc;
               if (cpu_done) begin
                  if (nxt_found) begin
                     state   <= S_CHECK_ADDR;
                     chk_idx <= nxt_idx;
                     dm_addr <= chk_addr[nxt_idx];
                  end else begin
                     state     <= S_DONE;
                     cpu_reset <= 1'b1;
                  end
               end else if (run_inc == RC_W'(TIMEOUT)) begin
                  fail      <= 1'b1;
                  timed_out <= 1'b1;
                  cpu_reset <= 1'b1;
                  state     <= S_DONE;
               end
            end
            S_CHECK_ADDR: begin
               state <= S_CHECK_CMP;
            end
            S_CHECK_CMP: begin
               // Only the first mismatch is recorded. Later checks still run.
               if (cmp_bad && !fail) begin
                  fail     <= 1'b1;
                  fail_idx <= chk_idx;
`ifdef TSEQ_MISMATCH_CAPTURE_EN
                  fail_exp <= chk_data[chk_idx];
                  fail_act <= dm_rdata;
`endif
               end
               if (nxt_found) begin
                  state   <= S_CHECK_ADDR;
                  chk_idx <= nxt_idx;
                  dm_addr <= chk_addr[nxt_idx];
               end else begin
                  state     <= S_DONE;
                  cpu_reset <= 1'b1;
               end
            end
            S_DONE: begin
               pass  <= !fail;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_test_sequencer.sv
// Directed bench for cpu_test_sequencer. It contains a behavioural DM/RF and
// a tiny CPU model. The CPU model raises done a programmable number of cycles
// after release, and can write one DM word while it runs.
module tb_cpu_test_sequencer;

   localparam int TO = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we, cfg_chk, cfg_is_rf, cfg_valid;
   logic [2:0] cfg_idx;
   logic [7:0] cfg_addr, cfg_data;
   logic       start;
   logic       dm_we, rf_we, cpu_reset, cpu_done;
   logic [7:0] dm_addr, dm_wdata, dm_rdata, rf_wdata;
   logic [2:0] rf_addr;
   logic       busy, pass, fail, timed_out;
   logic [1:0] fail_idx;
   logic [4:0] run_cycles;
`ifdef TSEQ_MISMATCH_CAPTURE_EN
   logic [7:0] fail_exp, fail_act;
`endif

   always #5 clk = ~clk;

   cpu_test_sequencer #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .cfg_we(cfg_we), .cfg_chk(cfg_chk), .cfg_idx(cfg_idx), .cfg_is_rf(cfg_is_rf),
      .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .start(start),
      .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
      .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
      .cpu_reset(cpu_reset), .cpu_done(cpu_done),
      .busy(busy), .pass(pass), .fail(fail), .timed_out(timed_out),
      .fail_idx(fail_idx), .run_cycles(run_cycles)
`ifdef TSEQ_MISMATCH_CAPTURE_EN
      , .fail_exp(fail_exp), .fail_act(fail_act)
`endif
   );

   // Memory and CPU models
   logic [7:0] dm [256];
   logic [7:0] rf [8];
   logic       model_en;
   int         done_at;
   logic [7:0] model_waddr, model_wdata;
   int         cnt = 0;
   int         dm_we_cnt = 0, rf_we_cnt = 0, both_cnt = 0;

   assign cpu_done = model_en && !cpu_reset && (cnt >= done_at - 1);

   always @(posedge clk) begin
      cnt <= cpu_reset ? 0 : cnt + 1;
      if (dm_we) dm[dm_addr] <= dm_wdata;
      if (model_en && !cpu_reset && cnt == 1) dm[model_waddr] <= model_wdata;
      dm_rdata <= dm[dm_addr];
      if (rf_we) rf[rf_addr] <= rf_wdata;
      if (dm_we) dm_we_cnt <= dm_we_cnt + 1;
      if (rf_we) rf_we_cnt <= rf_we_cnt + 1;
      if (dm_we && rf_we) both_cnt <= both_cnt + 1;
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cfg_write(input logic chk, input logic [2:0] idx, input logic is_rf,
                            input logic valid, input logic [7:0] addr, input logic [7:0] data);
      @(negedge clk);
      cfg_we = 1'b1; cfg_chk = chk; cfg_idx = idx; cfg_is_rf = is_rf;
      cfg_valid = valid; cfg_addr = addr; cfg_data = data;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wait_idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic wait_rc(input logic [4:0] target);
      int n = 0;
      while (run_cycles != target && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("wait_run_cycles", 32'(run_cycles), 32'(target));
   endtask

   int d0, r0;

   initial begin
      rst_n = 1'b0; start = 1'b0;
      cfg_we = 1'b0; cfg_chk = 1'b0; cfg_idx = '0; cfg_is_rf = 1'b0;
      cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
      model_en = 1'b0; done_at = 12; model_waddr = '0; model_wdata = '0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pass_fail", 32'({pass, fail, timed_out}), 32'd0);
      check("rst_fail_idx", 32'(fail_idx), 32'd0);
      check("rst_run_cycles", 32'(run_cycles), 32'd0);
      check("rst_we", 32'({dm_we, rf_we}), 32'd0);
      check("rst_dm_addr", 32'(dm_addr), 32'd0);
      rst_n = 1'b1;

      // Add: DM[1]=3, DM[0]=4, RF6=0, RF1=1, RF7=0; expect DM[0]=7
      cfg_write(0, 0, 0, 1, 8'h01, 8'h03);
      cfg_write(0, 1, 0, 1, 8'h00, 8'h04);
      cfg_write(0, 2, 1, 1, 8'h06, 8'h00);
      cfg_write(0, 3, 1, 1, 8'h01, 8'h01);
      cfg_write(0, 4, 1, 1, 8'h07, 8'h00);
      cfg_write(1, 0, 0, 1, 8'h00, 8'h07);
      model_en = 1'b1; done_at = 12; model_waddr = 8'h00; model_wdata = 8'h07;
      d0 = dm_we_cnt; r0 = rf_we_cnt;
      pulse_start();
      check("add_busy_running", 32'(busy), 32'd1);
      wait_idle();
      check("add_pass", 32'({pass, fail, timed_out}), 32'b100);
      check("add_run_cycles", 32'(run_cycles), 32'd12);
      check("add_cpu_reset", 32'(cpu_reset), 32'd1);
      check("add_dm_writes", 32'(dm_we_cnt - d0), 32'd2);
      check("add_rf_writes", 32'(rf_we_cnt - r0), 32'd3);
      check("add_rf1", 32'(rf[1]), 32'd1);
      check("add_dm1", 32'(dm[1]), 32'd3);

      // Mismatch: DM[2]=9 but expected 5 (idx1); idx2 expects DM[1]=0x55 (also wrong)
      cfg_write(0, 5, 0, 1, 8'h02, 8'h09);
      cfg_write(1, 1, 0, 1, 8'h02, 8'h05);
      cfg_write(1, 2, 0, 1, 8'h01, 8'h55);
      pulse_start();
      wait_idle();
      check("mis_flags", 32'({pass, fail, timed_out}), 32'b010);
      check("mis_fail_idx", 32'(fail_idx), 32'd1);
      check("mis_run_cycles", 32'(run_cycles), 32'd12);
`ifdef TSEQ_MISMATCH_CAPTURE_EN
      check("mis_fail_exp", 32'(fail_exp), 32'h05);
      check("mis_fail_act", 32'(fail_act), 32'h09);
`endif

      // Timeout: done never rises; last init write was DM[2], checks must not move dm_addr
      model_en = 1'b0;
      pulse_start();
      wait_idle();
      check("to_flags", 32'({pass, fail, timed_out}), 32'b011);
      check("to_run_cycles", 32'(run_cycles), 32'd16);
      check("to_fail_idx", 32'(fail_idx), 32'd0);
      check("to_no_dm_read", 32'(dm_addr), 32'h02);

      // Skip/override: idx0 DM[4]=0x11, idx1 RF2=0x5A, idx2 invalid, idx3 DM[4]=0x22
      cfg_write(0, 0, 0, 1, 8'h04, 8'h11);
      cfg_write(0, 1, 1, 1, 8'h02, 8'h5A);
      cfg_write(0, 2, 0, 0, 8'h04, 8'h33);
      cfg_write(0, 3, 0, 1, 8'h04, 8'h22);
      cfg_write(0, 4, 0, 0, 8'h00, 8'h00);
      cfg_write(0, 5, 0, 0, 8'h00, 8'h00);
      cfg_write(1, 0, 0, 1, 8'h04, 8'h22);
      cfg_write(1, 1, 0, 0, 8'h00, 8'h00);
      cfg_write(1, 2, 0, 0, 8'h00, 8'h00);
      model_en = 1'b1; model_waddr = 8'h80; model_wdata = 8'h00;
      d0 = dm_we_cnt; r0 = rf_we_cnt;
      pulse_start();
      wait_idle();
      check("ovr_pass", 32'({pass, fail, timed_out}), 32'b100);
      check("ovr_dm4", 32'(dm[4]), 32'h22);
      check("ovr_rf2", 32'(rf[2]), 32'h5A);
      check("ovr_dm_writes", 32'(dm_we_cnt - d0), 32'd2);
      check("ovr_rf_writes", 32'(rf_we_cnt - r0), 32'd1);

      // Reset in the middle of RUN
      pulse_start();
      wait_rc(5'd5);
      rst_n = 1'b0;
      #1;
      check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_pass_fail", 32'({pass, fail}), 32'd0);
      check("midrst_run_cycles", 32'(run_cycles), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      d0 = dm_we_cnt; r0 = rf_we_cnt;
      pulse_start();
      wait_idle();
      check("midrst_pass", 32'({pass, fail, timed_out}), 32'b100);
      check("midrst_run_cycles2", 32'(run_cycles), 32'd12);
      check("midrst_tables_cleared", 32'((dm_we_cnt - d0) + (rf_we_cnt - r0)), 32'd0);

      // Start and table writes during RUN are ignored
      cfg_write(1, 0, 0, 1, 8'h00, 8'h07);
      model_waddr = 8'h00; model_wdata = 8'h07;
      pulse_start();
      wait_rc(5'd3);
      cfg_write(1, 1, 0, 1, 8'h00, 8'h99);
      cfg_write(0, 0, 0, 1, 8'h00, 8'hEE);
      pulse_start();
      check("ign_busy", 32'(busy), 32'd1);
      wait_idle();
      check("ign_pass", 32'({pass, fail, timed_out}), 32'b100);
      check("ign_run_cycles", 32'(run_cycles), 32'd12);
      d0 = dm_we_cnt;
      pulse_start();
      wait_idle();
      check("ign_pass_rerun", 32'({pass, fail}), 32'b10);
      check("ign_no_init_write", 32'(dm_we_cnt - d0), 32'd0);
      check("ign_dm0", 32'(dm[0]), 32'h07);

      check("we_exclusive", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
